// File: rtl/fb_port_arbiter.sv
// Frame-buffer port arbiter: display reads > clear engine > pixel writer on one BRAM port.
// The clear engine is only built when FB_ARB_CLEAR_EN is defined; otherwise the grant is read > writer.
module fb_port_arbiter #(
  parameter int ADDR_W = 17,
  parameter int DATA_W = 16,
  parameter int DEPTH  = 76800
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rd_req,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              clear_start,
  input  logic [DATA_W-1:0] clear_color,
  output logic              clear_busy,
  output logic              clear_done,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  logic              rd_pend;
  logic              clr_grant;
  logic              idle;
  logic [ADDR_W-1:0] clr_addr;
  logic [DATA_W-1:0] clr_wdata;

`ifdef FB_ARB_CLEAR_EN
  typedef enum logic {IDLE, CLEAR} state_t;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  state_t            state;
  logic [ADDR_W-1:0] cnt;
  logic [DATA_W-1:0] color;

  assign idle      = (state == IDLE);
  assign clr_grant = (state == CLEAR) && !rd_req;
  assign clr_addr  = cnt;
  assign clr_wdata = color;

  // The counter only advances on a granted write, so a read stealing the port never skips a pixel.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= '0;
      color      <= '0;
      clear_busy <= 1'b0;
      clear_done <= 1'b0;
    end else begin
      clear_done <= 1'b0;
      case (state)
        IDLE: begin
          if (clear_start) begin
            state      <= CLEAR;
            cnt        <= '0;
            color      <= clear_color;
            clear_busy <= 1'b1;
          end
        end
        CLEAR: begin
          if (clr_grant) begin
            if (cnt == LAST_ADDR) begin
              state      <= IDLE;
              clear_busy <= 1'b0;
              clear_done <= 1'b1;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
`else
  wire        unused_clear = ^{clear_start, clear_color};
  wire [31:0] unused_depth = DEPTH;

  assign idle       = 1'b1;
  assign clr_grant  = 1'b0;
  assign clr_addr   = '0;
  assign clr_wdata  = '0;
  assign clear_busy = 1'b0;
  assign clear_done = 1'b0;
`endif

  // Grants are gated by rst_n so the port is quiet while reset is held.
  always_comb begin
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    wr_ready  = 1'b0;
    if (rst_n) begin
      if (rd_req) begin
        mem_en   = 1'b1;
        mem_addr = rd_addr;
      end else if (clr_grant) begin
        mem_en    = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = clr_addr;
        mem_wdata = clr_wdata;
      end else if (idle) begin
        wr_ready = 1'b1;
        if (wr_valid) begin
          mem_en    = 1'b1;
          mem_we    = 1'b1;
          mem_addr  = wr_addr;
          mem_wdata = wr_data;
        end
      end
    end
  end

  // BRAM has one cycle of read latency; rd_data is registered one cycle after that.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_pend  <= 1'b0;
      rd_valid <= 1'b0;
      rd_data  <= '0;
    end else begin
      rd_pend  <= rd_req;
      rd_valid <= rd_pend;
      if (rd_pend) rd_data <= mem_rdata;
    end
  end

endmodule

// File: doc/fb_port_arbiter.md
Name: fb_port_arbiter

Overview:
- Shares the single-port 320x240 RGB565 frame buffer between three users: the VGA display read path, the pixel writer (renderer), and an internal clear engine.
- Display reads have absolute priority so scan-out never stalls. The clear engine and the writer use the remaining cycles, mostly during blanking.
- Sits between the VGA controller, the renderer and the frame buffer BRAM.

Parameters:
- ADDR_W, 17, frame-buffer address width.
- DATA_W, 16, pixel width (RGB565).
- DEPTH, 76800, number of pixels (320*240); the clear range is 0..DEPTH-1.

Ports:
- clk  in  1  25 MHz pixel clock.
- rst_n  in  1  reset; asynchronous assert, active low.
- rd_req  in  1  display read request this cycle.
- rd_addr  in  ADDR_W  display read address.
- rd_data  out  DATA_W  returned pixel.
- rd_valid  out  1  rd_data valid strobe.
- wr_valid  in  1  writer has a pixel.
- wr_ready  out  1  writer pixel accepted this cycle.
- wr_addr  in  ADDR_W  writer address.
- wr_data  in  DATA_W  writer pixel.
- clear_start  in  1  one-cycle pulse that starts a full-buffer fill.
- clear_color  in  DATA_W  fill value, sampled on clear_start.
- clear_busy  out  1  clear in progress.
- clear_done  out  1  one-cycle pulse after the last clear write.
- mem_en  out  1  BRAM enable.
- mem_we  out  1  BRAM write enable.
- mem_addr  out  ADDR_W  BRAM address.
- mem_wdata  out  DATA_W  BRAM write data.
- mem_rdata  in  DATA_W  BRAM read data; synchronous, 1-cycle latency.

Behaviour:
- Reset values (async on rst_n low): rd_valid=0, rd_data=0, clear_busy=0, clear_done=0, clear counter=0, latched color=0, state=IDLE. Combinational outputs then evaluate to: mem_en=0, mem_we=0, mem_addr=0, mem_wdata=0, wr_ready=0.
- Per-cycle grant is combinational on the current inputs and state, with fixed priority: rd_req > clear engine (state CLEAR) > writer.
- Read grant:
  - mem_en=1, mem_we=0, mem_addr=rd_addr.
  - Pipeline: rd_req sampled at edge N, mem_rdata presented in cycle N+1, registered into rd_data with rd_valid=1 in cycle N+2.
  - Fixed latency of 2 cycles. Back-to-back reads give one result per cycle.
- Clear grant:
  - mem_en=1, mem_we=1, mem_addr=counter, mem_wdata=latched color; counter increments.
  - A read in the same cycle takes the port; the clear counter holds and is not skipped.
- Writer grant: only when rd_req=0 and state=IDLE.
  - wr_ready=1 in that case, otherwise wr_ready=0.
  - If wr_valid=1: mem_en=1, mem_we=1, mem_addr=wr_addr, mem_wdata=wr_data.
  - wr_ready does not depend on wr_valid, so the writer may sample it freely.
- No granted user: mem_en=0, mem_we=0, mem_addr=0, mem_wdata=0.
- Transaction rules:
  - Each mem transaction is a single cycle; there is no read-modify-write.
  - A pixel is considered written at the edge where wr_valid & wr_ready are both high.
- State machine: IDLE, CLEAR.
  - IDLE -> CLEAR on clear_start. Counter is set to 0, clear_color is latched, clear_busy=1 from the next cycle.
  - CLEAR -> IDLE on the edge that commits address DEPTH-1. clear_busy then drops, and clear_done=1 for exactly one cycle.
  - clear_start while in CLEAR is ignored; no restart and no color change.
- Boundary conditions:
  - The clear counter never exceeds DEPTH-1 and no wrap-around write occurs.
  - Writes to wr_addr >= DEPTH are forwarded unmodified; the BRAM ignores them.
  - rst_n asserted mid-clear aborts immediately: pixels already written stay written, and no clear_done is produced.
  - rst_n asserted with a read in flight drops that read's rd_valid.
  - rd_req and wr_valid both high: read granted, wr_ready=0, the writer holds its data.

Optional Feature:
- Macro: FB_ARB_CLEAR_EN.
  - Defined: clear engine, CLEAR state, clear_* behaviour exactly as above.
  - Undefined: ports remain for interface stability; clear_start and clear_color are ignored, clear_busy=0 and clear_done=0 always, and the grant is rd_req > writer only.

Test Plan:
- Reset release, all inputs 0 -> mem_en=0, wr_ready=1, rd_valid=0, clear_busy=0.
- rd_req on addresses 5, 6, 7 in consecutive cycles, BRAM model preloaded with addr*3 -> rd_valid in cycles 2, 3, 4 with rd_data 15, 18, 21.
- wr_valid with addr 100 / data 16'hF800 while rd_req pulses high for 3 cycles -> wr_ready=0 for those 3 cycles, a single write to 100 when rd_req drops, no duplicate write.
- clear_start, clear_color=16'h001F, no reads -> 76800 writes to addresses 0..76799, clear_done one cycle after the last write, wr_ready=0 throughout.
- Clear with rd_req asserted every 2nd cycle -> every address 0..76799 is written exactly once, reads keep their 2-cycle latency, clear_start re-pulsed mid-clear has no effect.
- rst_n low at counter=1000 during clear -> immediate IDLE, no clear_done, and the next clear_start restarts from address 0.
